keypad_scanner: RTL and testbench

- Input-side counterpart to the multiplexed seven-segment driver. The display scans anodes outward; this block scans the rows of a 4x4 matrix keypad and reads the columns back.
- Debounces the scanned matrix and decodes single key presses into 4-bit hex codes.
- Presents each press on a one-entry valid/ready output buffer, feeding the alarm-clock time/alarm-set logic.

---
 rtl/kpd_pkg.sv | 28 ++
 rtl/keypad_debounce.sv | 79 +++++++
 rtl/keypad_scanner.sv | 94 +++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kpd_pkg.sv
// rtl/kpd_pkg.sv - keypad geometry, keymap and row-drive encoding shared by the scanner
package kpd_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef logic [1:0]          row_idx_t;
  typedef logic [NUM_KEYS-1:0] frame_t;

  // Indexed by {row, col}; frame bit 4r+c holds the key at row r, column c.
  localparam logic [3:0] KEYMAP [NUM_KEYS] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  localparam logic [3:0] ROW_DRIVE [NUM_ROWS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [3:0] key_index(input frame_t keys);
    key_index = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) key_index = i[3:0];
    end
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - full-frame debounce, debounced key state and press-event decode
module keypad_debounce
  import kpd_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_capture,
  input  row_idx_t   i_row_idx,
  input  logic [3:0] i_cols,
  output logic       o_press,
  output logic [3:0] o_code,
  output logic       o_key_down
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  frame_t        r_frame;
  frame_t        r_prev;
  frame_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic [3:0]    r_code;
  logic          r_key_down;

  frame_t        w_frame;
  logic [CW-1:0] w_cnt_next;
  logic          w_frame_end;
  logic          w_update;
  logic          w_press;

  // The row being captured this cycle is merged in so the frame end sees the whole matrix.
  always_comb begin
    w_frame = r_frame;
    w_frame[{i_row_idx, 2'b00} +: 4] = i_cols;
  end

  always_comb begin
    w_cnt_next = CW'(1);
    if (w_frame == r_prev) begin
      w_cnt_next = (r_cnt == CW'(DEBOUNCE_SCANS)) ? r_cnt : r_cnt + CW'(1);
    end
  end

  assign w_frame_end = i_capture && (i_row_idx == 2'd3);
  assign w_update    = w_frame_end && (w_cnt_next == CW'(DEBOUNCE_SCANS));
  // Only a clean release-to-single-key transition counts; ghosted combos never fire.
  assign w_press     = w_update && (r_state == '0) && $onehot(w_frame);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_frame    <= '0;
      r_prev     <= '0;
      r_state    <= '0;
      r_cnt      <= '0;
      r_press    <= 1'b0;
      r_code     <= '0;
      r_key_down <= 1'b0;
    end else begin
      r_press <= w_press;
      if (i_capture) r_frame <= w_frame;
      if (w_frame_end) begin
        r_prev <= w_frame;
        r_cnt  <= w_cnt_next;
      end
      if (w_update) begin
        r_state    <= w_frame;
        r_key_down <= |w_frame;
      end
      if (w_press) r_code <= KEYMAP[key_index(w_frame)];
    end
  end

  assign o_press    = r_press;
  assign o_code     = r_code;
  assign o_key_down = r_key_down;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad row scan, column sync and one-entry key buffer
module keypad_scanner
  import kpd_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_col,
  output logic [3:0] o_row,
  input  logic       i_key_ready,
  output logic       o_key_valid,
  output logic [3:0] o_key_code,
  output logic       o_key_down,
  output logic       o_overrun
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] r_div;
  row_idx_t      r_row_idx;
  logic [3:0]    r_col_meta;
  logic [3:0]    r_col_sync;
  logic          r_key_valid;
  logic [3:0]    r_key_code;
  logic          r_overrun;

  logic          w_div_tc;
  logic          w_press;
  logic [3:0]    w_code;

  assign w_div_tc = (r_div == DW'(SCAN_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_div     <= '0;
      r_row_idx <= '0;
    end else if (w_div_tc) begin
      r_div     <= '0;
      r_row_idx <= r_row_idx + 2'd1;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Released (all high) is the safe idle value for the synchronizer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
    end else begin
      r_col_meta <= i_col;
      r_col_sync <= r_col_meta;
    end
  end

  assign o_row = ROW_DRIVE[r_row_idx];

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_capture  (w_div_tc),
    .i_row_idx  (r_row_idx),
    .i_cols     (~r_col_sync),
    .o_press    (w_press),
    .o_code     (w_code),
    .o_key_down (o_key_down)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_overrun   <= 1'b0;
    end else if (w_press) begin
      if (!r_key_valid || i_key_ready) begin
        r_key_code  <= w_code;
        r_key_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_key_valid && i_key_ready) begin
      r_key_valid <= 1'b0;
    end
  end

  assign o_key_valid = r_key_valid;
  assign o_key_code  = r_key_code;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a frame-level keypad model
module tb_keypad_scanner;

  localparam int S     = 4;
  localparam int D     = 2;
  localparam int FRAME = 4 * S;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        ready = 1'b1;
  logic        valid;
  logic [3:0]  code;
  logic        key_down;
  logic        overrun;

  logic [15:0] kmat = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_got = 0;

  string       KEYS_STR = "123A456B789C0FED";

  int          n;
  logic [15:0] m_d1, m_d2, m_frame, m_prev, m_state;
  int          m_run;
  logic        m_pend, m_valid, m_ovr;
  logic [3:0]  m_pend_code;
  logic [3:0]  exp_q[$];

  keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_SCANS(D)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_col       (col),
    .o_row       (row),
    .i_key_ready (ready),
    .o_key_valid (valid),
    .o_key_code  (code),
    .o_key_down  (key_down),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Ideal matrix: a closed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) col = col & ~kmat[4*r +: 4];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] hexval(input logic [7:0] ch);
    if (ch >= 8'h41) return 4'(ch - 8'h37);
    return 4'(ch - 8'h30);
  endfunction

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << (4*r + c);
  endfunction

  // Reference model: each row is seen 2 cycles late, a frame is judged every 4*S cycles.
  initial begin
    logic [15:0] cap;
    int r;
    forever begin
      @(posedge clk);
      if (!rst) begin
        n = 0; m_d1 = '0; m_d2 = '0; m_frame = '0; m_prev = '0; m_state = '0;
        m_run = 0; m_pend = 1'b0; m_pend_code = '0; m_valid = 1'b0; m_ovr = 1'b0;
        exp_q.delete();
      end else begin
        n++;
        if (m_pend) begin
          if (!m_valid || ready) begin
            exp_q.push_back(m_pend_code);
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else if (m_valid && ready) begin
          m_valid = 1'b0;
        end
        m_pend = 1'b0;
        cap = m_d2; m_d2 = m_d1; m_d1 = kmat;
        if (n % S == 0) begin
          r = (n / S - 1) % 4;
          m_frame[4*r +: 4] = cap[4*r +: 4];
          if (r == 3) begin
            if (m_frame == m_prev) m_run = (m_run < D) ? m_run + 1 : D;
            else m_run = 1;
            m_prev = m_frame;
            if (m_run == D) begin
              if (m_state == '0 && $countones(m_frame) == 1) begin
                m_pend = 1'b1;
                for (int i = 0; i < 16; i++)
                  if (m_frame[i]) m_pend_code = hexval(KEYS_STR.getc(i));
              end
              m_state = m_frame;
            end
          end
        end
      end
    end
  end

  // Monitor: compare every cycle, pop the scoreboard on each completed handshake.
  initial begin
    logic [3:0] one;
    logic [3:0] e;
    one = 4'b0001;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        check("rst_row", row, 4'b1110);
        check("rst_key_valid", valid, 0);
        check("rst_key_code", code, 0);
        check("rst_key_down", key_down, 0);
        check("rst_overrun", overrun, 0);
      end else begin
        check("row", row, 4'hF & ~(one << ((n / S) % 4)));
        check("key_valid", valid, m_valid);
        check("key_down", key_down, m_state != '0);
        check("overrun", overrun, m_ovr);
        if (valid && ready) begin
          check("expected_key_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("key_code", code, e);
            n_got++;
          end
        end
      end
    end
  end

  task automatic set_keys(input logic [15:0] k, input int frames);
    kmat = k;
    repeat (frames * FRAME) @(negedge clk);
  endtask

  initial begin
    int base;
    logic [15:0] k;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    set_keys('0, 3);

    base = n_got;
    set_keys(key(1, 1), 4);
    check("key5_code", code, 4'h5);
    check("key5_down", key_down, 1);
    set_keys('0, 4);
    check("key5_released", key_down, 0);
    check("key5_events", n_got - base, 1);

    base = n_got;
    repeat (7) begin
      kmat = kmat ^ key(3, 3);
      repeat (5) @(negedge clk);
    end
    set_keys(key(3, 3), 4);
    check("keyD_code", code, 4'hD);
    set_keys('0, 4);
    check("keyD_events", n_got - base, 1);

    base = n_got;
    set_keys(key(0, 0) | key(0, 1), 4);
    check("ghost_pair_events", n_got - base, 0);
    check("ghost_pair_down", key_down, 1);
    set_keys(key(0, 0), 4);
    check("ghost_partial_events", n_got - base, 0);
    set_keys('0, 4);
    set_keys(key(0, 0), 4);
    check("key1_code", code, 4'h1);
    check("key1_events", n_got - base, 1);
    set_keys('0, 4);

    ready = 1'b0;
    set_keys(key(2, 0), 4);
    set_keys('0, 4);
    set_keys(key(2, 1), 4);
    set_keys('0, 4);
    check("ovr_valid", valid, 1);
    check("ovr_code", code, 4'h7);
    check("ovr_flag", overrun, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk); #1;
    check("ovr_valid_after_pulse", valid, 0);
    check("ovr_sticky", overrun, 1);
    ready = 1'b1;

    kmat = key(2, 2);
    repeat (FRAME) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_overrun", overrun, 0);
    check("midrst_row", row, 4'b1110);
    repeat (3) @(negedge clk);
    base = n_got;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_early_event", n_got - base, 0);
    set_keys(key(2, 2), 3);
    check("key9_events", n_got - base, 1);
    check("key9_code", code, 4'h9);
    set_keys('0, 4);

    for (int it = 0; it < 10; it++) begin
      k = key($urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) k = k | key($urandom_range(0, 3), $urandom_range(0, 3));
      ready = ($urandom_range(0, 3) != 0);
      kmat = k;
      repeat ($urandom_range(2 * FRAME, 5 * FRAME)) @(negedge clk);
      ready = ($urandom_range(0, 2) != 0);
      kmat = '0;
      repeat ($urandom_range(2 * FRAME, 4 * FRAME)) @(negedge clk);
    end
    ready = 1'b1;
    set_keys('0, 4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
